// File: rtl/rdport_mux.sv
// rdport_mux: per-read-agent read port of the multi-write/multi-read RAM.
// Asks the write-ownership accounter which bank last wrote the requested row,
// reads only that bank, follows the selection through the bank read latency,
// and returns the data through a credit-protected, in-order response FIFO.
// Ports:
//   aclk, aresetn                    clock, asynchronous active-low reset
//   req_valid_i/req_ready_o/req_addr_i  read request handshake and row address
//   acc_rden_o/acc_rdaddr_o          accounter query strobe and address
//   acc_rdselect_i                   owning bank, combinational on acc_rdaddr_o
//   bank_rden_o/bank_rdaddr_o        one-hot bank read enable, shared address
//   bank_rddata_i                    all bank read data, bank i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid_o/rsp_ready_i/rsp_data_o  response handshake and data
module rdport_mux #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int NB_WRAGENT   = 2,
  parameter int SELECT_WIDTH = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT),
  parameter int RAM_LATENCY  = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [ADDR_WIDTH-1:0]            req_addr_i,
  output logic                             acc_rden_o,
  output logic [ADDR_WIDTH-1:0]            acc_rdaddr_o,
  input  logic [SELECT_WIDTH-1:0]          acc_rdselect_i,
  output logic [NB_WRAGENT-1:0]            bank_rden_o,
  output logic [ADDR_WIDTH-1:0]            bank_rdaddr_o,
  input  logic [NB_WRAGENT*DATA_WIDTH-1:0] bank_rddata_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [DATA_WIDTH-1:0]            rsp_data_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  if (RAM_LATENCY < 1 || RAM_LATENCY > 4) begin : g_bad_latency
    $error("rdport_mux: RAM_LATENCY must be within 1..4");
  end
  if (FIFO_DEPTH < RAM_LATENCY + 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rdport_mux: FIFO_DEPTH must be a power of two and >= RAM_LATENCY+1");
  end

  logic                    accept, push, pop;
  logic [DATA_WIDTH-1:0]   push_data;
  logic [RAM_LATENCY-1:0]  vld_q;
  logic [SELECT_WIDTH-1:0] sel_q [RAM_LATENCY];
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]           fcnt_q, fcnt_d, cnt_q, cnt_d;

  // cnt_q covers in-flight plus buffered reads, so an accepted read always has a FIFO slot
  assign req_ready_o   = aresetn & (cnt_q < CW'(FIFO_DEPTH));
  assign accept        = req_valid_i & req_ready_o;
  assign acc_rden_o    = accept;
  assign acc_rdaddr_o  = req_addr_i;
  assign bank_rdaddr_o = req_addr_i;
  assign bank_rden_o   = accept ? NB_WRAGENT'(1) << acc_rdselect_i : '0;

  assign push        = vld_q[RAM_LATENCY-1];
  assign push_data   = bank_rddata_i[sel_q[RAM_LATENCY-1]*DATA_WIDTH +: DATA_WIDTH];
  assign rsp_valid_o = fcnt_q != '0;
  assign rsp_data_o  = mem_q[rptr_q];
  assign pop         = rsp_valid_o & rsp_ready_i;

  always_comb begin
    cnt_d  = cnt_q + CW'(accept) - CW'(pop);
    fcnt_d = fcnt_q + CW'(push) - CW'(pop);
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_q  <= '0;
      cnt_q  <= '0;
      fcnt_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) sel_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      vld_q[0] <= accept;
      sel_q[0] <= acc_rdselect_i;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        sel_q[i] <= sel_q[i-1];
      end
      // when full, a push only coincides with a pop, so the slot written is the one being freed
      if (push) mem_q[wptr_q] <= push_data;
      cnt_q  <= cnt_d;
      fcnt_q <= fcnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  assert property (@(posedge aclk) disable iff (!aresetn) push |-> (fcnt_q != CW'(FIFO_DEPTH) || pop));
endmodule

// File: tb/tb_rdport_mux.sv
// tb_rdport_mux: directed bench for rdport_mux with a queue-based response model.
// Instance 0: RAM_LATENCY=1, FIFO_DEPTH=4. Instance 1: RAM_LATENCY=3, FIFO_DEPTH=8.
module tb_rdport_mux;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NB = 2;

  typedef struct packed { logic [DW-1:0] d; int due; } ent_t;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic          rstn        [2];
  logic          req_valid   [2];
  logic          req_ready   [2];
  logic [AW-1:0] req_addr    [2];
  logic          acc_rden    [2];
  logic [AW-1:0] acc_rdaddr  [2];
  logic          acc_rdselect[2];
  logic [NB-1:0] bank_rden   [2];
  logic [AW-1:0] bank_rdaddr [2];
  logic [NB*DW-1:0] bank_rddata[2];
  logic          rsp_valid   [2];
  logic          rsp_ready   [2];
  logic [DW-1:0] rsp_data    [2];

  logic          own [256];
  logic [DW-1:0] mem [NB][256];

  logic [DW-1:0] rlog  [2][64];
  int            rn    [2];
  int            acc_n [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
    return a[0] ? (a ^ 8'hAA) : (a ^ 8'h55);
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int LAT = (k == 0) ? 1 : 3;
    localparam int FD  = (k == 0) ? 4 : 8;
    logic [NB*DW-1:0] bpipe [LAT];
    ent_t q[$];

    rdport_mux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_WRAGENT(NB),
                 .RAM_LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
      .aclk(aclk), .aresetn(rstn[k]),
      .req_valid_i(req_valid[k]), .req_ready_o(req_ready[k]), .req_addr_i(req_addr[k]),
      .acc_rden_o(acc_rden[k]), .acc_rdaddr_o(acc_rdaddr[k]), .acc_rdselect_i(acc_rdselect[k]),
      .bank_rden_o(bank_rden[k]), .bank_rdaddr_o(bank_rdaddr[k]), .bank_rddata_i(bank_rddata[k]),
      .rsp_valid_o(rsp_valid[k]), .rsp_ready_i(rsp_ready[k]), .rsp_data_o(rsp_data[k]));

    assign acc_rdselect[k] = own[acc_rdaddr[k]];
    assign bank_rddata[k]  = bpipe[LAT-1];

    always @(posedge aclk) begin
      for (int b = 0; b < NB; b++)
        bpipe[0][b*DW +: DW] <= bank_rden[k][b] ? mem[b][bank_rdaddr[k]] : '0;
      for (int i = 1; i < LAT; i++) bpipe[i] <= bpipe[i-1];
    end

    always @(negedge aclk) begin
      logic er, ev, ac;
      logic [NB-1:0] erd;
      ent_t e;
      if (!rstn[k]) q.delete();
      er  = rstn[k] && q.size() < FD;
      ev  = q.size() > 0 && q[0].due <= cyc;
      ac  = req_valid[k] && er;
      erd = ac ? (2'b01 << own[req_addr[k]]) : 2'b00;
      chk($sformatf("req_ready%0d", k), req_ready[k], er);
      chk($sformatf("acc_rden%0d", k), acc_rden[k], ac);
      chk($sformatf("bank_rden%0d", k), bank_rden[k], erd);
      chk($sformatf("rsp_valid%0d", k), rsp_valid[k], ev);
      if (ev) chk($sformatf("rsp_data%0d", k), rsp_data[k], q[0].d);
      if (ev && rsp_ready[k]) begin
        if (rn[k] < 64) rlog[k][rn[k]] = rsp_data[k];
        rn[k]++;
        void'(q.pop_front());
      end
      if (ac) begin
        e.d   = mem[own[req_addr[k]]][req_addr[k]];
        e.due = cyc + LAT + 1;
        q.push_back(e);
        acc_n[k]++;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int base, rb, na;
    for (int k = 0; k < 2; k++) begin
      rstn[k] = 1'b0; req_valid[k] = 1'b0; req_addr[k] = '0; rsp_ready[k] = 1'b1;
      rn[k] = 0; acc_n[k] = 0;
    end
    for (int a = 0; a < 256; a++) begin
      own[a]    <= a[0];
      mem[0][a] <= 8'(a) ^ 8'h55;
      mem[1][a] <= 8'(a) ^ 8'hAA;
    end
    own[16]    <= 1'b1;
    mem[0][16] <= 8'h3C;
    mem[1][16] <= 8'hA5;
    @(negedge aclk);
    chk("rst_ready", req_ready[0], 0);
    chk("rst_valid", rsp_valid[0], 0);
    repeat (2) @(posedge aclk);
    #1;
    rstn[0] = 1'b1; rstn[1] = 1'b1;
    @(negedge aclk);
    chk("ready_after_rst", req_ready[0], 1);
    chk("ready_after_rst1", req_ready[1], 1);
    repeat (3) begin
      tick();
      @(negedge aclk);
      chk("idle_valid", rsp_valid[0], 0);
      chk("idle_rden", bank_rden[0], 0);
    end
    tick();

    req_valid[0] = 1'b1; req_addr[0] = 8'h10;
    @(negedge aclk);
    chk("single_rden", bank_rden[0], 2'b10);
    tick();
    req_valid[0] = 1'b0;
    @(negedge aclk);
    chk("single_t1_valid", rsp_valid[0], 0);
    tick();
    @(negedge aclk);
    chk("single_t2_valid", rsp_valid[0], 1);
    chk("single_t2_data", rsp_data[0], 8'hA5);
    tick();

    base = rn[0];
    for (int i = 0; i < 16; i++) begin
      req_valid[0] = 1'b1; req_addr[0] = 8'(i);
      @(negedge aclk);
      chk("stream_ready", req_ready[0], 1);
      tick();
    end
    req_valid[0] = 1'b0;
    repeat (4) tick();
    chk("stream_count", rn[0] - base, 16);
    for (int i = 0; i < 16; i++) chk("stream_data", rlog[0][base+i], f(8'(i)));

    rsp_ready[0] = 1'b0; na = 0; base = acc_n[0]; rb = rn[0];
    for (int c = 0; c < 8; c++) begin
      req_valid[0] = 1'b1; req_addr[0] = 8'h30 + 8'(na);
      @(negedge aclk);
      if (req_ready[0]) na++;
      tick();
    end
    chk("bp_accepts", acc_n[0] - base, 4);
    rsp_ready[0] = 1'b1;
    @(negedge aclk);
    chk("bp_full_ready", req_ready[0], 0);
    chk("bp_full_valid", rsp_valid[0], 1);
    tick();
    rsp_ready[0] = 1'b0; req_addr[0] = 8'h34;
    @(negedge aclk);
    chk("bp_reopen", req_ready[0], 1);
    tick();
    @(negedge aclk);
    chk("bp_reclose", req_ready[0], 0);
    tick();
    chk("bp_accepts2", acc_n[0] - base, 5);
    chk("bp_handshakes", rn[0] - rb, 1);
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
    repeat (8) tick();
    chk("bp_drain", rn[0] - rb, 5);
    for (int j = 0; j < 5; j++) chk("bp_order", rlog[0][rb+j], f(8'h30 + 8'(j)));

    rb = rn[0];
    req_valid[0] = 1'b1; req_addr[0] = 8'h20;
    @(posedge aclk);
    own[32]    <= 1'b1;
    mem[1][32] <= 8'hE7;
    #1;
    tick();
    req_valid[0] = 1'b0;
    repeat (4) tick();
    chk("rdw_count", rn[0] - rb, 2);
    chk("rdw_old", rlog[0][rb], 8'h75);
    chk("rdw_new", rlog[0][rb+1], 8'hE7);

    rsp_ready[1] = 1'b0; base = acc_n[1]; rb = rn[1];
    for (int j = 0; j < 5; j++) begin
      req_valid[1] = 1'b1; req_addr[1] = 8'h40 + 8'(j);
      @(negedge aclk);
      chk("mf_ready", req_ready[1], 1);
      tick();
    end
    req_valid[1] = 1'b0; rstn[1] = 1'b0;
    @(negedge aclk);
    chk("mf_rst_valid", rsp_valid[1], 0);
    chk("mf_rst_ready", req_ready[1], 0);
    tick();
    rstn[1] = 1'b1; rsp_ready[1] = 1'b1;
    chk("mf_accepts", acc_n[1] - base, 5);
    repeat (8) begin
      @(negedge aclk);
      chk("mf_no_old", rsp_valid[1], 0);
      tick();
    end
    chk("mf_dropped", rn[1] - rb, 0);
    req_valid[1] = 1'b1; req_addr[1] = 8'h50;
    @(negedge aclk);
    chk("mf_new_rden", bank_rden[1], 2'b01);
    tick();
    req_valid[1] = 1'b0;
    repeat (6) tick();
    chk("mf_new_count", rn[1] - rb, 1);
    chk("mf_new_data", rlog[1][rb], 8'h05);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
